line_buffer_window_reader: RTL and testbench
============================================

Name: line_buffer_window_reader

Overview:
- Read side of the convolution line buffer. The row writer fills KER_SIZE+1 row SRAMs and raises row_ready once KER_SIZE rows are resident.
- This block walks the resident rows column by column and applies left/right zero padding.
- It also applies the top/bottom row pad masks and emits stride-decimated KER_SIZE x KER_SIZE windows to the conv engine over a valid/ready handshake.

Parameters:
- KER_SIZE, 3, kernel height/width.
- BITWIDTH, 8, bits per activation.
- NFMAPS, 3, feature maps per SRAM word; DW = NFMAPS*BITWIDTH.
- INPUT_X_DIM, 28, unpadded row length in columns.
- PAD, 1, zero columns on each side (0 <= PAD < KER_SIZE).
- STRIDE, 1, horizontal window stride (>= 1).
- AW, 5, SRAM address width (2^AW >= INPUT_X_DIM).

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- row_ready, input, 1, KER_SIZE rows resident; request to read one output row.
- wr_row_sel, input, KER_SIZE+1, one-hot row SRAM currently being written.
- top_pad_mask, input, KER_SIZE, bit r=1 zeroes window row r.
- bot_pad_mask, input, KER_SIZE, bit r=1 zeroes window row r.
- rd_en, output, KER_SIZE+1, per-SRAM read enable.
- rd_addr, output, AW, column address, shared by all SRAMs.
- rd_data, input, (KER_SIZE+1)*DW, SRAM outputs; SRAM j at [j*DW +: DW]; valid one cycle after rd_en.
- win_valid, output, 1, window available.
- win_ready, input, 1, consumer accepts window.
- win_data, output, KER_SIZE*KER_SIZE*DW, element (r,k) at [(r*KER_SIZE+k)*DW +: DW]; r=0 is the oldest row, k=0 the leftmost column.
- row_busy, output, 1, high from row start until row_done; the writer must not overwrite readable rows while high.
- row_done, output, 1, one-cycle pulse after the last window of a row is accepted.

Behaviour:
- Reset: state IDLE; all counters 0; rd_en=0; rd_addr=0; win_valid=0; win_data=0; row_busy=0; row_done=0; skid empty.
- Reset mid-row: aborts immediately. Nothing resumes; next row starts only on a fresh row_ready.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN when row_ready=1. In that cycle, snapshot wr_row_sel, top_pad_mask and bot_pad_mask; clear the column and window counters; row_busy=1 from the next cycle.
- Row mapping: window row r reads SRAM (w+1+r) mod (KER_SIZE+1), where w is the index of the snapshotted write row. The resulting window row is zeroed if the snapshot top or bottom mask bit r is set.
- RUN: padded column counter pc steps 0..PX-1, with PX = INPUT_X_DIM + 2*PAD.
  - Padding column (pc < PAD or pc >= PAD+INPUT_X_DIM): no SRAM access; an all-zero column enters the pipeline.
  - Data column: rd_en = mapped row bits (KER_SIZE ones; the write row is never enabled), rd_addr = pc - PAD. Data is captured one cycle later.
- Column pipeline:
  - Each fetched column shifts into a KER_SIZE-deep column register; the new column enters at k = KER_SIZE-1.
  - A shift is blocked while win_valid=1 and win_ready=0.
  - A column returning while the shift is blocked goes into a 1-entry skid register. The skid drains first when unblocked.
- Fetch gating: no fetch (pc holds, rd_en=0) in any cycle where the skid is full, or win_valid=1 and win_ready=0.
- Window emission: on a shift that pushes padded column c, win_valid is set next cycle iff c >= KER_SIZE-1 and (c-(KER_SIZE-1)) mod STRIDE == 0.
  - win_data is registered and held stable while win_valid=1 and win_ready=0.
  - win_valid deasserts after the handshake unless another window is produced in that same cycle. Back-to-back windows at STRIDE=1 with win_ready held high are allowed.
- Window count per row: OUT_X = (PX - KER_SIZE)/STRIDE + 1.
- RUN -> DRAIN after the fetch of pc = PX-1.
- DRAIN -> IDLE once the skid is empty and the last window is accepted. That transition cycle drives row_done=1 and row_busy=0.
- row_ready is ignored outside IDLE. If it is held high, a new row starts the cycle after row_done.
- Data latency (data column): fetch at t, capture/shift at t+1, win_valid at t+2 when it completes a window.
- Column counter width is ceil(log2(PX+1)). The stride counter wraps at STRIDE-1.

Test Plan:
- Defaults, row SRAM j preloaded with value 16*j + column; wr_row_sel=4'b0001; masks 0; win_ready tied 1; pulse row_ready.
  -> Exactly 28 windows.
  -> Window 0 column k=0 is zero; its rows come from SRAMs 1, 2, 3.
  -> Window 27 column k=2 is zero.
  -> row_done is a single pulse after the 28th handshake.
- STRIDE=2, same data.
  -> 14 windows (OUT_X=14), whose leftmost padded columns are 0, 2, ..., 26.
- top_pad_mask=3'b001, then separately bot_pad_mask=3'b100.
  -> Window row 0 (respectively row 2) is all zero in every window; other rows are unaltered.
- Random win_ready backpressure, including deassertion in the cycle a window completes.
  -> No window lost or duplicated.
  -> win_data stable while stalled.
  -> rd_en never asserts while the skid is full.
  -> Window sequence identical to the unstalled run.
- wr_row_sel rotated 0001 -> 0010 -> 0100 -> 1000 across four rows.
  -> rd_en never includes the write row.
  -> Row order rotates correctly; row_busy high for each whole row.
- rstn asserted mid-row (after window 10), then released.
  -> All outputs return to reset values immediately.
  -> The next row_ready yields a complete 28-window row.

Source files
------------

// File: rtl/line_buffer_window_reader_if.sv
// Window handshake between the line-buffer reader (master) and the conv engine (slave).
interface line_buffer_window_reader_if #(
    parameter int KER_SIZE = 3,
    parameter int DW       = 24
);
    logic                            win_valid;
    logic                            win_ready;
    logic [KER_SIZE*KER_SIZE*DW-1:0] win_data;

    modport master (output win_valid, output win_data, input win_ready);
    modport slave  (input win_valid, input win_data, output win_ready);
endinterface

// File: rtl/line_buffer_window_reader.sv
// Read side of the convolution line buffer: walks the resident rows column by
// column, inserts left/right zero padding, applies the top/bottom row masks and
// emits stride-decimated KxK windows over a valid/ready handshake.
module line_buffer_window_reader #(
    parameter int KER_SIZE    = 3,
    parameter int BITWIDTH    = 8,
    parameter int NFMAPS      = 3,
    parameter int INPUT_X_DIM = 28,
    parameter int PAD         = 1,
    parameter int STRIDE      = 1,
    parameter int AW          = 5
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    row_ready,
    input  logic [KER_SIZE:0]                       wr_row_sel,
    input  logic [KER_SIZE-1:0]                     top_pad_mask,
    input  logic [KER_SIZE-1:0]                     bot_pad_mask,
    output logic [KER_SIZE:0]                       rd_en,
    output logic [AW-1:0]                           rd_addr,
    input  logic [(KER_SIZE+1)*NFMAPS*BITWIDTH-1:0] rd_data,
    line_buffer_window_reader_if.master             win,
    output logic                                    row_busy,
    output logic                                    row_done
);
    localparam int DW = NFMAPS * BITWIDTH;
    localparam int CD = KER_SIZE * DW;
    localparam int WD = KER_SIZE * CD;
    localparam int PX = INPUT_X_DIM + 2 * PAD;
    localparam int CW = $clog2(PX + 1);
    localparam int RW = $clog2(KER_SIZE + 1);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    // Window row r lives in the SRAM just after the write row, rotating upward.
    function automatic logic [RW-1:0] map_row(input logic [RW-1:0] w, input int r);
        int s;
        s = (int'(w) + 1 + r) % (KER_SIZE + 1);
        return RW'(s);
    endfunction

    function automatic logic [RW-1:0] onehot_idx(input logic [KER_SIZE:0] sel);
        logic [RW-1:0] idx;
        idx = '0;
        for (int j = 0; j <= KER_SIZE; j++) begin
            if (sel[j]) idx = RW'(j);
        end
        return idx;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     pc_q, pc_d;
    logic [RW-1:0]     w_q, w_d;
    logic [KER_SIZE-1:0] zmask_q, zmask_d;
    logic              fv_q, fv_d;
    logic              fpad_q, fpad_d;
    logic [CW-1:0]     fcol_q, fcol_d;
    logic              skid_v_q, skid_v_d;
    logic [CD-1:0]     skid_col_q, skid_col_d;
    logic [CW-1:0]     skid_c_q, skid_c_d;
    logic [CD-1:0]     cols_q [KER_SIZE];
    logic [CD-1:0]     cols_d [KER_SIZE];
    logic [SW-1:0]     str_q, str_d;
    logic              win_valid_q, win_valid_d;
    logic [WD-1:0]     win_data_q, win_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              stall_s, data_col_s, fetch_s, shift_s, emit_s;
    logic [KER_SIZE:0] rd_mask_s;
    logic [CD-1:0]     ret_col_s, in_col_s;
    logic [CW-1:0]     in_c_s;
    logic [CD-1:0]     sh_s [KER_SIZE];

    // Datapath decode: fetch gating, SRAM read request, returning column and shift.
    always_comb begin
        stall_s    = win_valid_q & ~win.win_ready;
        data_col_s = (pc_q >= CW'(PAD)) && (pc_q < CW'(PAD + INPUT_X_DIM));
        fetch_s    = (state_q == S_RUN) && !skid_v_q && !stall_s;
        rd_mask_s  = '0;
        ret_col_s  = '0;
        for (int r = 0; r < KER_SIZE; r++) begin
            rd_mask_s[map_row(w_q, r)] = 1'b1;
            if (fpad_q || zmask_q[r]) begin
                ret_col_s[r*DW +: DW] = '0;
            end else begin
                ret_col_s[r*DW +: DW] = rd_data[int'(map_row(w_q, r))*DW +: DW];
            end
        end
        shift_s  = !stall_s && (skid_v_q || fv_q);
        in_col_s = skid_v_q ? skid_col_q : ret_col_s;
        in_c_s   = skid_v_q ? skid_c_q : fcol_q;
        for (int k = 0; k < KER_SIZE - 1; k++) begin
            sh_s[k] = cols_q[k+1];
        end
        sh_s[KER_SIZE-1] = in_col_s;
        emit_s  = shift_s && (in_c_s >= CW'(KER_SIZE - 1)) && (str_q == '0);
        rd_en   = (fetch_s && data_col_s) ? rd_mask_s : '0;
        rd_addr = (fetch_s && data_col_s) ? AW'(pc_q - CW'(PAD)) : '0;
    end

    // Next-state logic: skid, column shift, window emission and the row FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        w_d         = w_q;
        zmask_d     = zmask_q;
        fv_d        = 1'b0;
        fpad_d      = fpad_q;
        fcol_d      = fcol_q;
        skid_v_d    = skid_v_q;
        skid_col_d  = skid_col_q;
        skid_c_d    = skid_c_q;
        cols_d      = cols_q;
        str_d       = str_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // A column arriving while the shift is blocked parks in the skid.
        if (shift_s && skid_v_q) begin
            skid_v_d = 1'b0;
        end else if (fv_q && stall_s) begin
            skid_v_d   = 1'b1;
            skid_col_d = ret_col_s;
            skid_c_d   = fcol_q;
        end else begin
            skid_v_d = skid_v_q;
        end

        if (shift_s) begin
            cols_d = sh_s;
            if (in_c_s >= CW'(KER_SIZE - 1)) begin
                str_d = (str_q == SW'(STRIDE - 1)) ? '0 : str_q + SW'(1);
            end else begin
                str_d = str_q;
            end
        end else begin
            str_d = str_q;
        end

        if (emit_s) begin
            win_valid_d = 1'b1;
            for (int r = 0; r < KER_SIZE; r++) begin
                for (int k = 0; k < KER_SIZE; k++) begin
                    win_data_d[(r*KER_SIZE+k)*DW +: DW] = sh_s[k][r*DW +: DW];
                end
            end
        end else if (win.win_ready) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (row_ready) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    str_d   = '0;
                    w_d     = onehot_idx(wr_row_sel);
                    zmask_d = top_pad_mask | bot_pad_mask;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_RUN: begin
                if (fetch_s) begin
                    fv_d   = 1'b1;
                    fpad_d = !data_col_s;
                    fcol_d = pc_q;
                    pc_d   = pc_q + CW'(1);
                    if (pc_q == CW'(PX - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!fv_q && !skid_v_q && (!win_valid_q || win.win_ready)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            w_q         <= '0;
            zmask_q     <= '0;
            fv_q        <= 1'b0;
            fpad_q      <= 1'b0;
            fcol_q      <= '0;
            skid_v_q    <= 1'b0;
            skid_col_q  <= '0;
            skid_c_q    <= '0;
            for (int k = 0; k < KER_SIZE; k++) begin
                cols_q[k] <= '0;
            end
            str_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            w_q         <= w_d;
            zmask_q     <= zmask_d;
            fv_q        <= fv_d;
            fpad_q      <= fpad_d;
            fcol_q      <= fcol_d;
            skid_v_q    <= skid_v_d;
            skid_col_q  <= skid_col_d;
            skid_c_q    <= skid_c_d;
            cols_q      <= cols_d;
            str_q       <= str_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign win.win_valid = win_valid_q;
    assign win.win_data  = win_data_q;
    assign row_busy      = busy_q;
    assign row_done      = done_q;
endmodule

// File: tb/tb_line_buffer_window_reader.sv
// Bench for line_buffer_window_reader: two instances (STRIDE 1 and 2) share the
// stimulus; a window-level model predicts every accepted window.
module tb_line_buffer_window_reader;
    localparam int K  = 3;
    localparam int DW = 24;
    localparam int WD = K * K * DW;
    localparam int NS = K + 1;
    localparam int OUTX [2] = '{28, 14};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, row_ready, win_ready, bp;
    logic [3:0] wr_row_sel;
    logic [2:0] top_m, bot_m;

    logic [1:0][3:0]    rd_en_a;
    logic [1:0][4:0]    rd_addr_a;
    logic [1:0]         wv_a, busy_a, done_a;
    logic [1:0][WD-1:0] wd_a;

    // Bench-side row context, set by the stimulus before each row
    logic [3:0] cur_sel;
    int         cur_w, test_id, to_cnt;

    // Compare-process state
    int            n_checks = 0, n_errs = 0, cyc_n = 0, to_seen = 0;
    int            n_acc [2], rows_done [2], last_hs [2];
    logic          busy_e [2], skid_e [2], prev_stall [2], prev_rd_nz [2], prev_done [2];
    logic [WD-1:0] prev_data [2], cap0 [2], capL [2];
    logic          rr_prev, stall_v;

    genvar g;
    for (g = 0; g < 2; g++) begin : gen
        logic [NS*DW-1:0] rdd;
        logic [3:0]       rde;
        logic [4:0]       rda;
        logic             busy, done;
        line_buffer_window_reader_if #(.KER_SIZE(K), .DW(DW)) wif ();
        assign wif.win_ready = win_ready;
        line_buffer_window_reader #(.STRIDE(g + 1)) dut (
            .clk(clk), .rstn(rstn), .row_ready(row_ready), .wr_row_sel(wr_row_sel),
            .top_pad_mask(top_m), .bot_pad_mask(bot_m), .rd_en(rde), .rd_addr(rda),
            .rd_data(rdd), .win(wif), .row_busy(busy), .row_done(done));
        // Row SRAMs: word at column x of SRAM j holds 16*j + x, one-cycle read latency
        always @(posedge clk) begin
            for (int j = 0; j < NS; j++) begin
                if (rde[j]) rdd[j*DW +: DW] <= DW'(16 * j) + DW'(rda);
            end
        end
        assign rd_en_a[g]   = rde;
        assign rd_addr_a[g] = rda;
        assign wv_a[g]      = wif.win_valid;
        assign wd_a[g]      = wif.win_data;
        assign busy_a[g]    = busy;
        assign done_a[g]    = done;
    end

    // Expected window n of a row: leftmost padded column n*st, padded columns are
    // zero, masked rows are zero, window row r comes from SRAM (w+1+r) mod 4.
    function automatic logic [WD-1:0] model_win(input int st, input int w, input logic [2:0] zr, input int n);
        logic [WD-1:0] res;
        int c, j;
        res = '0;
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                c = n * st + k;
                j = (w + 1 + r) % NS;
                if (!zr[r] && c >= 1 && c <= 28) res[(r*K+k)*DW +: DW] = DW'(16 * j + c - 1);
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] el(input logic [WD-1:0] w, input int r, input int k);
        return w[(r*K+k)*DW +: DW];
    endfunction

    task automatic chk(input string nm, input int inst, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, inst, cyc_n, act, exp);
        end
    endtask

    // Compare process: checks both instances on every falling edge.
    always @(negedge clk) begin
        cyc_n++;
        chk("row_timeout", 0, WD'(to_cnt), WD'(to_seen));
        to_seen = to_cnt;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                chk("reset_ctrl", i, WD'({rd_en_a[i], rd_addr_a[i], wv_a[i], busy_a[i], done_a[i]}), WD'(0));
                chk("reset_win_data", i, wd_a[i], WD'(0));
                n_acc[i] = 0; busy_e[i] = 1'b0; skid_e[i] = 1'b0; prev_stall[i] = 1'b0;
                prev_rd_nz[i] = 1'b0; prev_done[i] = 1'b0; last_hs[i] = 0;
            end else begin
                stall_v = wv_a[i] & ~win_ready;
                if (rd_en_a[i] != 4'd0) chk("rd_en_rows", i, WD'(rd_en_a[i]), WD'(~cur_sel & 4'hF));
                if (stall_v || skid_e[i]) chk("rd_en_gated", i, WD'(rd_en_a[i]), WD'(0));
                if (rr_prev) busy_e[i] = 1'b1;
                if (done_a[i]) busy_e[i] = 1'b0;
                chk("row_busy", i, WD'(busy_a[i]), WD'(busy_e[i]));
                if (prev_stall[i]) begin
                    chk("stall_valid", i, WD'(wv_a[i]), WD'(1));
                    chk("stall_data", i, wd_a[i], prev_data[i]);
                end
                if (wv_a[i] && win_ready) begin
                    if (n_acc[i] >= OUTX[i]) begin
                        chk("extra_window", i, WD'(n_acc[i] + 1), WD'(OUTX[i]));
                    end else begin
                        chk("win_data", i, wd_a[i], model_win(i + 1, cur_w, top_m | bot_m, n_acc[i]));
                        if (n_acc[i] == 0) cap0[i] = wd_a[i];
                        if (n_acc[i] == OUTX[i] - 1) capL[i] = wd_a[i];
                    end
                    n_acc[i]++;
                    last_hs[i] = cyc_n;
                end
                if (done_a[i]) begin
                    chk("window_count", i, WD'(n_acc[i]), WD'(OUTX[i]));
                    chk("row_done_pulse", i, WD'(prev_done[i]), WD'(0));
                    chk("row_done_timing", i, WD'((cyc_n - last_hs[i] >= 1) && (i != 0 || cyc_n - last_hs[i] == 1)), WD'(1));
                    if (test_id == 1 && i == 0) begin
                        chk("pin_w0_k0_pad", i, WD'(el(cap0[0], 0, 0)), WD'(0));
                        chk("pin_w0_r0k1", i, WD'(el(cap0[0], 0, 1)), WD'(16));
                        chk("pin_w0_r1k1", i, WD'(el(cap0[0], 1, 1)), WD'(32));
                        chk("pin_w0_r2k1", i, WD'(el(cap0[0], 2, 1)), WD'(48));
                        chk("pin_w0_r0k2", i, WD'(el(cap0[0], 0, 2)), WD'(17));
                        chk("pin_w27_k2_pad", i, WD'({el(capL[0], 0, 2), el(capL[0], 1, 2), el(capL[0], 2, 2)}), WD'(0));
                        chk("pin_w27_r0k1", i, WD'(el(capL[0], 0, 1)), WD'(43));
                        chk("pin_w27_r2k0", i, WD'(el(capL[0], 2, 0)), WD'(74));
                    end
                    if (test_id == 1 && i == 1) begin
                        chk("pin_s2_w13_r0k0", i, WD'(el(capL[1], 0, 0)), WD'(41));
                        chk("pin_s2_w13_r1k1", i, WD'(el(capL[1], 1, 1)), WD'(58));
                        chk("pin_s2_w13_r2k2", i, WD'(el(capL[1], 2, 2)), WD'(75));
                    end
                    rows_done[i]++;
                    n_acc[i] = 0;
                end
                // Skid holds a column from a fetch answered into a stalled cycle until the first unstalled cycle
                skid_e[i]     = (skid_e[i] | prev_rd_nz[i]) & stall_v;
                prev_rd_nz[i] = (rd_en_a[i] != 4'd0);
                prev_stall[i] = stall_v;
                prev_data[i]  = wd_a[i];
                prev_done[i]  = done_a[i];
            end
        end
        rr_prev = rstn & row_ready;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        win_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic start_row(input logic [3:0] sel, input logic [2:0] t, input logic [2:0] b, input int tid);
        wr_row_sel = sel; top_m = t; bot_m = b; cur_sel = sel; test_id = tid;
        for (int j = 0; j < NS; j++) begin
            if (sel[j]) cur_w = j;
        end
        row_ready = 1'b1;
        cyc();
        row_ready = 1'b0;
    endtask

    task automatic run_row(input logic [3:0] sel, input logic [2:0] t, input logic [2:0] b, input int tid);
        int d0, d1, lim;
        d0 = rows_done[0]; d1 = rows_done[1]; lim = 0;
        start_row(sel, t, b, tid);
        while ((rows_done[0] == d0 || rows_done[1] == d1) && lim < 2000) begin
            cyc();
            lim++;
        end
        if (lim >= 2000) to_cnt++;
        cyc();
    endtask

    initial begin
        int lim;
        rstn = 1'b0; row_ready = 1'b0; win_ready = 1'b1; bp = 1'b0;
        wr_row_sel = 4'b0001; top_m = 3'b000; bot_m = 3'b000;
        cur_sel = 4'b0001; cur_w = 0; test_id = 0; to_cnt = 0;
        rows_done[0] = 0; rows_done[1] = 0;
        repeat (3) cyc();
        rstn = 1'b1;
        cyc();
        run_row(4'b0001, 3'b000, 3'b000, 1);
        run_row(4'b0001, 3'b001, 3'b000, 2);
        run_row(4'b0001, 3'b000, 3'b100, 3);
        bp = 1'b1;
        run_row(4'b0001, 3'b000, 3'b000, 4);
        run_row(4'b0010, 3'b000, 3'b000, 5);
        run_row(4'b0100, 3'b000, 3'b000, 6);
        run_row(4'b1000, 3'b000, 3'b000, 7);
        bp = 1'b0;
        cyc();
        // Abort a row after window 10 has been accepted
        start_row(4'b0001, 3'b000, 3'b000, 8);
        lim = 0;
        while (n_acc[0] < 11 && lim < 500) begin
            cyc();
            lim++;
        end
        if (lim >= 500) to_cnt++;
        rstn = 1'b0;
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
        run_row(4'b0001, 3'b000, 3'b000, 9);
        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
